// File: rtl/pa_seq_pkg.sv
// ---------------------------------------------------------------------------
// pa_seq_pkg
// Shared definitions for the P-A ALU multiply/divide sequencer:
//   state_e        - sequencer states
//   MODE_MW/DW     - operation mode held for the length of an operation
//   STEPS_DEFAULT  - iterations per operation (one per operand bit)
// ---------------------------------------------------------------------------
package pa_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK,
        ST_S1,
        ST_S2,
        ST_DONE
    } state_e;

    localparam logic MODE_MW = 1'b0;
    localparam logic MODE_DW = 1'b1;

    localparam int STEPS_DEFAULT = 16;

endpackage : pa_seq_pkg

// File: rtl/pa_seq_cnt.sv
// ---------------------------------------------------------------------------
// pa_seq_cnt
// Iteration counter for the arithmetic sequencer. Clear wins over increment,
// and the counter holds at the terminal count instead of wrapping, so an
// operation can never roll over into step 0 on its own.
//
// Ports:
//   clk_i   - clock
//   rst_ni  - synchronous reset, active low
//   clr_i   - clear the count to 0
//   inc_i   - advance one step (ignored at terminal count)
//   step_o  - current iteration index
//   tc_o    - terminal count, step_o == STEPS-1
// ---------------------------------------------------------------------------
module pa_seq_cnt #(
    parameter int STEPS = 16,
    parameter int CW    = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] step_o,
    output logic          tc_o
);

    logic [CW-1:0] step_q;
    logic [CW-1:0] step_d;

    assign tc_o   = (step_q == CW'(STEPS - 1));
    assign step_o = step_q;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        step_d = step_q;
        if (clr_i) begin
            step_d = '0;
        end else if (inc_i && !tc_o) begin
            step_d = step_q + 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments; reset is synchronous, sampled on the clock edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            step_q <= '0;
        end else begin
            step_q <= step_d;
        end
    end

endmodule : pa_seq_cnt

// File: rtl/pa_arith_seq.sv
// ---------------------------------------------------------------------------
// pa_arith_seq
// Multi-cycle control sequencer for the P-A ALU datapath: 16-bit
// shift-and-add multiply (MW) and restoring divide (DW) on the AC:AT pair.
// Each step takes two cycles: S1 (strob1) and S2 (strob2). Divide is
// preceded by one CHK cycle that rejects quotients that cannot fit.
//
// Ports:
//   clk_sys, rst_        - clock, synchronous active-low reset
//   start_mw, start_dw   - one-cycle start pulses (multiply has priority)
//   abort                - synchronous cancel back to idle
//   at15_                - AT LSB (multiplier bit), active low
//   carry_               - ALU carry, active low (low = carry / no borrow)
//   zdiv                 - divisor is zero, sampled with start_dw
//   busy, done, ovf      - status; ovf is sticky until the next start
//   strob1, strob2, as2  - phase strobes
//   w_ac, apb, amb       - AC write enable, ALU add/subtract selects
//   sh_r, sh_l, sh_in    - AC:AT shift controls and right-shift fill bit
//   qset                 - set quotient bit AT[15]
//   step                 - current iteration index
// ---------------------------------------------------------------------------
module pa_arith_seq
    import pa_seq_pkg::*;
#(
    parameter int STEPS = STEPS_DEFAULT,
    parameter int CW    = 4
) (
    input  logic          clk_sys,
    input  logic          rst_,
    input  logic          start_mw,
    input  logic          start_dw,
    input  logic          abort,
    input  logic          at15_,
    input  logic          carry_,
    input  logic          zdiv,
    output logic          busy,
    output logic          done,
    output logic          ovf,
    output logic          strob1,
    output logic          strob2,
    output logic          as2,
    output logic          w_ac,
    output logic          apb,
    output logic          amb,
    output logic          sh_r,
    output logic          sh_l,
    output logic          sh_in,
    output logic          qset,
    output logic [CW-1:0] step
);

    state_e state_q;
    logic   mode_q;
    logic   ovf_q;
    logic   c_q;      // carry out of the last multiply add, fills AC[0] on the shift
    logic   start_ok;
    logic   tc;

    assign start_ok = (state_q == ST_IDLE) && (start_mw || start_dw) && !abort;

    pa_seq_cnt #(
        .STEPS (STEPS),
        .CW    (CW)
    ) u_cnt (
        .clk_i  (clk_sys),
        .rst_ni (rst_),
        .clr_i  (start_ok || abort),
        .inc_i  ((state_q == ST_S2) && !abort),
        .step_o (step),
        .tc_o   (tc)
    );

    always_ff @(posedge clk_sys) begin
        if (!rst_) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_MW;
            ovf_q   <= 1'b0;
            c_q     <= 1'b0;
        end else if (abort) begin
            // ovf survives an abort so the microprogram can still inspect it
            state_q <= ST_IDLE;
            c_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_mw) begin
                        mode_q  <= MODE_MW;
                        ovf_q   <= 1'b0;
                        state_q <= ST_S1;
                    end else if (start_dw) begin
                        mode_q  <= MODE_DW;
                        ovf_q   <= zdiv;
                        state_q <= zdiv ? ST_DONE : ST_CHK;
                    end
                end
                ST_CHK: begin
                    // AC >= A before any shift: quotient would exceed 16 bits
                    if (!carry_) begin
                        ovf_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_S1;
                    end
                end
                ST_S1: begin
                    if (mode_q == MODE_MW) begin
                        c_q <= !at15_ && !carry_;
                    end
                    state_q <= ST_S2;
                end
                ST_S2: begin
                    state_q <= tc ? ST_DONE : ST_S1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ovf = ovf_q;

    // The add/write and quotient decisions depend on at15_ and carry_ in the
    // same cycle the ALU produces them, so the control lines are decoded from
    // the registered state rather than registered themselves.
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        strob1 = 1'b0;
        strob2 = 1'b0;
        as2    = 1'b0;
        w_ac   = 1'b0;
        apb    = 1'b0;
        amb    = 1'b0;
        sh_r   = 1'b0;
        sh_l   = 1'b0;
        sh_in  = 1'b0;
        qset   = 1'b0;
        case (state_q)
            ST_CHK: begin
                busy   = 1'b1;
                strob1 = 1'b1;
                amb    = 1'b1;
            end
            ST_S1: begin
                busy   = 1'b1;
                strob1 = 1'b1;
                if (mode_q == MODE_MW) begin
                    apb  = !at15_;
                    w_ac = !at15_;
                end else begin
                    sh_l = 1'b1;
                end
            end
            ST_S2: begin
                busy   = 1'b1;
                strob2 = 1'b1;
                as2    = 1'b1;
                if (mode_q == MODE_MW) begin
                    sh_r  = 1'b1;
                    sh_in = c_q;
                end else begin
                    amb  = 1'b1;
                    w_ac = !carry_;
                    qset = !carry_;
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule : pa_arith_seq

// File: tb/tb_pa_arith_seq.sv
// ---------------------------------------------------------------------------
// tb_pa_arith_seq
// Drives multiply/divide operations with per-step multiplier bits and ALU
// carries, and compares every cycle's control outputs against a timeline
// model built from the operation's cycle schedule.
// ---------------------------------------------------------------------------
module tb_pa_arith_seq;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       ovf;
        logic       strob1;
        logic       strob2;
        logic       as2;
        logic       w_ac;
        logic       apb;
        logic       amb;
        logic       sh_r;
        logic       sh_l;
        logic       sh_in;
        logic       qset;
        logic [3:0] step;
    } obs_t;

    logic       clk_sys = 1'b0;
    logic       rst_    = 1'b0;
    logic       start_mw = 1'b0;
    logic       start_dw = 1'b0;
    logic       abort    = 1'b0;
    logic       at15_    = 1'b1;
    logic       carry_   = 1'b1;
    logic       zdiv     = 1'b0;
    logic       busy, done, ovf, strob1, strob2, as2, w_ac, apb, amb;
    logic       sh_r, sh_l, sh_in, qset;
    logic [3:0] step;

    int   n_checks = 0;
    int   n_pass   = 0;
    logic ovf_m    = 1'b0;
    logic [3:0] step_m = '0;

    pa_arith_seq #(.STEPS(16), .CW(4)) dut (
        .clk_sys  (clk_sys),
        .rst_     (rst_),
        .start_mw (start_mw),
        .start_dw (start_dw),
        .abort    (abort),
        .at15_    (at15_),
        .carry_   (carry_),
        .zdiv     (zdiv),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .strob1   (strob1),
        .strob2   (strob2),
        .as2      (as2),
        .w_ac     (w_ac),
        .apb      (apb),
        .amb      (amb),
        .sh_r     (sh_r),
        .sh_l     (sh_l),
        .sh_in    (sh_in),
        .qset     (qset),
        .step     (step)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish (got timeout, need completion)");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h need %h (busy,done,ovf,s1,s2,as2,w_ac,apb,amb,shr,shl,shin,qset,step)",
                     tag, got, exp);
        end
    endtask

    function automatic obs_t observe();
        obs_t o;
        o = {busy, done, ovf, strob1, strob2, as2, w_ac, apb, amb, sh_r, sh_l, sh_in, qset, step};
        return o;
    endfunction

    function automatic obs_t idle_exp();
        obs_t e;
        e      = '0;
        e.ovf  = ovf_m;
        e.step = step_m;
        return e;
    endfunction

    // One operation. atb[k]: at15_ during step k's S1 (MW). cb[k]: carry_
    // during step k's S1 (MW) or S2 (DW). chk_c: carry_ during CHK.
    // abort_at / rst_at / busy_start_at: cycle for that event (0 = none).
    task automatic run_op(input string name, input bit is_dw, input bit both, input bit zd,
                          input bit chk_c, input logic [15:0] atb, input logic [15:0] cb,
                          input int abort_at, input int rst_at, input int busy_start_at,
                          input bit start_at_done);
        bit   mw, zd_path, chk_ovf;
        int   len, k;
        obs_t e;
        mw      = !is_dw || both;
        zd_path = !mw && zd;
        chk_ovf = !mw && !zd && !chk_c;
        len     = mw ? 33 : zd_path ? 1 : chk_ovf ? 2 : 34;

        @(posedge clk_sys); #1;
        start_mw = mw;
        start_dw = is_dw || both;
        zdiv     = zd;
        abort    = 1'b0;
        rst_     = 1'b1;
        at15_    = 1'($urandom);
        carry_   = 1'($urandom);
        #1 check($sformatf("%s c0", name), observe(), idle_exp());

        ovf_m  = 1'b0;
        step_m = '0;
        for (int t = 1; t <= len + 1; t++) begin
            @(posedge clk_sys); #1;
            start_mw = 1'b0;
            start_dw = 1'b0;
            zdiv     = 1'($urandom);
            abort    = 1'b0;
            rst_     = 1'b1;
            at15_    = 1'($urandom);
            carry_   = 1'($urandom);
            if (zd_path) ovf_m = 1'b1;
            if (chk_ovf && t >= 2) ovf_m = 1'b1;
            e = idle_exp();
            if (t < len) begin
                e.busy = 1'b1;
                if (mw) begin
                    k      = (t - 1) / 2;
                    e.step = 4'(k);
                    if (t % 2 == 1) begin
                        at15_    = atb[k];
                        carry_   = cb[k];
                        e.strob1 = 1'b1;
                        e.apb    = !atb[k];
                        e.w_ac   = !atb[k];
                    end else begin
                        e.strob2 = 1'b1;
                        e.as2    = 1'b1;
                        e.sh_r   = 1'b1;
                        e.sh_in  = !atb[k] && !cb[k];
                    end
                end else if (t == 1) begin
                    carry_   = chk_c;
                    e.strob1 = 1'b1;
                    e.amb    = 1'b1;
                end else begin
                    k      = (t - 2) / 2;
                    e.step = 4'(k);
                    if (t % 2 == 0) begin
                        e.strob1 = 1'b1;
                        e.sh_l   = 1'b1;
                    end else begin
                        carry_   = cb[k];
                        e.strob2 = 1'b1;
                        e.as2    = 1'b1;
                        e.amb    = 1'b1;
                        e.w_ac   = !cb[k];
                        e.qset   = !cb[k];
                    end
                end
                step_m = e.step;
            end else if (t == len) begin
                e.done = 1'b1;
                if (start_at_done) start_mw = 1'b1;
            end
            if (t == busy_start_at) begin
                start_mw = 1'b1;
                start_dw = 1'b1;
            end
            if (t == abort_at) abort = 1'b1;
            if (t == rst_at)   rst_  = 1'b0;
            #1 check($sformatf("%s c%0d", name, t), observe(), e);

            if (t == abort_at || t == rst_at) begin
                if (t == rst_at) ovf_m = 1'b0;
                step_m = '0;
                @(posedge clk_sys); #1;
                abort = 1'b0;
                rst_  = 1'b1;
                #1 check($sformatf("%s cancel c%0d", name, t + 1), observe(), idle_exp());
                break;
            end
        end
        start_mw = 1'b0;
        start_dw = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk_sys);
        #1 check("reset", observe(), idle_exp());
        rst_ = 1'b1;

        // multiply, every multiplier bit set, no carries
        run_op("mw_all",   0, 0, 0, 1, 16'h0000, 16'hFFFF, 0, 0, 0, 0);
        // multiply, alternating multiplier bits, carry on each add
        run_op("mw_alt",   0, 0, 0, 1, 16'hAAAA, 16'h0000, 0, 0, 0, 0);
        // divide by zero
        run_op("dw_zdiv",  1, 0, 1, 1, 16'h0000, 16'hFFFF, 0, 0, 0, 0);
        // divide overflow detected in CHK, then a multiply clears ovf
        run_op("dw_chk",   1, 0, 0, 0, 16'h0000, 16'hFFFF, 0, 0, 0, 0);
        run_op("mw_clr",   0, 0, 0, 1, 16'h5A5A, 16'h3C3C, 0, 0, 0, 0);
        // normal divide, borrow-free subtract on every other step
        run_op("dw_norm",  1, 0, 0, 1, 16'h0000, 16'hAAAA, 0, 0, 0, 0);
        // both starts together: multiply wins
        run_op("both",     1, 1, 1, 0, 16'h1234, 16'h8765, 0, 0, 0, 0);
        // starts while busy and in the DONE cycle are ignored
        run_op("mw_busy",  0, 0, 0, 1, 16'hF0F0, 16'h0F0F, 0, 0, 7, 0);
        run_op("dw_busy",  1, 0, 0, 1, 16'h0000, 16'hC3C3, 0, 0, 20, 0);
        run_op("mw_dstrt", 0, 0, 0, 1, 16'h00FF, 16'hFF00, 0, 0, 0, 1);
        // abort mid-multiply; abort after a divide overflow keeps ovf
        run_op("mw_abort", 0, 0, 0, 1, 16'h0000, 16'h0000, 10, 0, 0, 0);
        run_op("dw_chk2",  1, 0, 0, 0, 16'h0000, 16'h0000, 2, 0, 0, 0);
        // reset in the middle of a divide
        run_op("dw_rst",   1, 0, 0, 1, 16'h0000, 16'h5555, 0, 15, 0, 0);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("rnd%0d", i), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
                   16'($urandom), 16'($urandom), 0, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pa_arith_seq
